// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: sequences a coefficient-bank load from coefficient memory into
// the FIR core, then feeds samples one at a time and collects each result,
// with a bounded wait per sample.
//
// state  | meaning
// IDLE   | accept a load request (priority) or a sample once coefficients exist
// LOAD   | issue NUM_TAPS memory reads, drain the two-stage write pipeline, pulse cfg_done
// SAMPLE | sample presented to the FIR core for one cycle
// WAIT   | wait for valid_out or for the timeout counter to reach TIMEOUT
//
// Load timing: reads run in the NUM_TAPS cycles after the accepted start; each
// read result reaches the FIR write port two cycles after its read strobe.
module fir_seq_ctrl #(
  parameter int NUM_TAPS = 64,
  parameter int TIMEOUT  = 4095
) (
  input  logic               clk2,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic [1:0]         cfg_bank,
  output logic               cfg_busy,
  output logic               cfg_done,
  output logic               coef_valid,
  output logic               mem_rd,
  output logic [7:0]         mem_addr,
  input  logic [15:0]        mem_rdata,
  output logic [15:0]        cin,
  output logic [5:0]         caddr,
  output logic               cload,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic signed [15:0] s_data,
  output logic signed [15:0] din,
  output logic               valid_in,
  input  logic               valid_out,
  input  logic signed [15:0] dout,
  output logic               m_valid,
  output logic signed [15:0] m_data,
  output logic               timeout_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SAMPLE = 2'd2, WAIT = 2'd3} state_t;

  localparam logic [5:0]  LAST_TAP = 6'(NUM_TAPS - 1);
  localparam logic [11:0] TO_CNT   = 12'(TIMEOUT);

  state_t             state_q, state_d;
  logic [1:0]         bank_q, bank_d;
  logic [5:0]         tap_q, tap_d;
  logic               rd_en_q, rd_en_d;
  logic               rd_dly_q, rd_dly_d;
  logic [5:0]         tap_dly_q, tap_dly_d;
  logic               cload_q, cload_d;
  logic [15:0]        cin_q, cin_d;
  logic [5:0]         caddr_q, caddr_d;
  logic               cfg_done_q, cfg_done_d;
  logic               coef_valid_q, coef_valid_d;
  logic signed [15:0] din_q, din_d;
  logic               valid_in_q, valid_in_d;
  logic               m_valid_q, m_valid_d;
  logic signed [15:0] m_data_q, m_data_d;
  logic [11:0]        wait_cnt_q, wait_cnt_d;
  logic               timeout_err_q, timeout_err_d;

  // Next-state, load pipeline and sample/result handling.
  always_comb begin
    state_d       = state_q;
    bank_d        = bank_q;
    tap_d         = tap_q;
    rd_en_d       = rd_en_q;
    rd_dly_d      = rd_en_q;
    tap_dly_d     = tap_q;
    cload_d       = rd_dly_q;
    cin_d         = rd_dly_q ? mem_rdata : cin_q;
    caddr_d       = rd_dly_q ? tap_dly_q : caddr_q;
    cfg_done_d    = cload_q && (caddr_q == LAST_TAP);
    coef_valid_d  = coef_valid_q | cfg_done_d;
    din_d         = din_q;
    valid_in_d    = 1'b0;
    m_valid_d     = 1'b0;
    m_data_d      = m_data_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = LOAD;
          bank_d  = cfg_bank;
          tap_d   = 6'd0;
          rd_en_d = 1'b1;
        end else if (s_valid && s_ready) begin
          din_d      = s_data;
          valid_in_d = 1'b1;
          state_d    = SAMPLE;
        end
      end
      LOAD: begin
        if (rd_en_q) begin
          if (tap_q == LAST_TAP) rd_en_d = 1'b0;
          else                   tap_d   = tap_q + 6'd1;
        end
        if (cfg_done_q) state_d = IDLE;
      end
      SAMPLE: begin
        wait_cnt_d = 12'd0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (valid_out) begin
          m_valid_d = 1'b1;
          m_data_d  = dout;
          state_d   = IDLE;
        end else if (wait_cnt_q == TO_CNT) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 12'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk2) begin
    if (rst) begin
      state_q       <= IDLE;
      bank_q        <= 2'd0;
      tap_q         <= 6'd0;
      rd_en_q       <= 1'b0;
      rd_dly_q      <= 1'b0;
      tap_dly_q     <= 6'd0;
      cload_q       <= 1'b0;
      cin_q         <= 16'd0;
      caddr_q       <= 6'd0;
      cfg_done_q    <= 1'b0;
      coef_valid_q  <= 1'b0;
      din_q         <= 16'sd0;
      valid_in_q    <= 1'b0;
      m_valid_q     <= 1'b0;
      m_data_q      <= 16'sd0;
      wait_cnt_q    <= 12'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bank_q        <= bank_d;
      tap_q         <= tap_d;
      rd_en_q       <= rd_en_d;
      rd_dly_q      <= rd_dly_d;
      tap_dly_q     <= tap_dly_d;
      cload_q       <= cload_d;
      cin_q         <= cin_d;
      caddr_q       <= caddr_d;
      cfg_done_q    <= cfg_done_d;
      coef_valid_q  <= coef_valid_d;
      din_q         <= din_d;
      valid_in_q    <= valid_in_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // A pending load request masks s_ready so the load wins a same-cycle race.
  always_comb begin
    s_ready = (state_q == IDLE) && coef_valid_q && !cfg_start;
  end

  assign cfg_busy    = (state_q == LOAD);
  assign cfg_done    = cfg_done_q;
  assign coef_valid  = coef_valid_q;
  assign mem_rd      = rd_en_q;
  assign mem_addr    = {bank_q, tap_q};
  assign cin         = cin_q;
  assign caddr       = caddr_q;
  assign cload       = cload_q;
  assign din         = din_q;
  assign valid_in    = valid_in_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: memory model, FIR-core response driver, directed
// load/sample sequences, a vector table and randomized sample transactions.
module tb_fir_seq_ctrl;

  logic               clk2 = 1'b0;
  logic               rst;
  logic               cfg_start;
  logic [1:0]         cfg_bank;
  logic               cfg_busy, cfg_done, coef_valid, mem_rd;
  logic [7:0]         mem_addr;
  logic [15:0]        mem_rdata = 16'd0;
  logic [15:0]        cin;
  logic [5:0]         caddr;
  logic               cload;
  logic               s_valid, s_ready;
  logic signed [15:0] s_data;
  logic signed [15:0] din;
  logic               valid_in;
  logic               valid_out;
  logic signed [15:0] dout;
  logic               m_valid;
  logic signed [15:0] m_data;
  logic               timeout_err;

  int tests = 0;
  int fails = 0;
  bit mon_on = 1'b0;

  always #5 clk2 = ~clk2;

  fir_seq_ctrl dut (
    .clk2(clk2), .rst(rst), .cfg_start(cfg_start), .cfg_bank(cfg_bank),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .coef_valid(coef_valid),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .cin(cin), .caddr(caddr), .cload(cload),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .din(din), .valid_in(valid_in), .valid_out(valid_out), .dout(dout),
    .m_valid(m_valid), .m_data(m_data), .timeout_err(timeout_err)
  );

  // Coefficient memory: word at addr is 0x1000+addr, one cycle read latency.
  always @(posedge clk2) mem_rdata <= mem_rd ? (16'h1000 + {8'h00, mem_addr}) : 16'hDEAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // cload, valid_in, m_valid and cfg_done must never overlap.
  always @(negedge clk2) begin
    if (mon_on) begin
      automatic int s = int'(cload) + int'(valid_in) + int'(m_valid) + int'(cfg_done);
      chk("pulse exclusivity", (s <= 1) ? 1 : 0, 1);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Launch a load; optionally hold a competing sample, optionally reset at a tap.
  task automatic run_load(input logic [1:0] bank, input bit hold, input int rst_tap, output int vin_at);
    int cl_cnt = 0, cl_bad = 0, done_cnt = 0, done_at = -1, busy_bad = 0, exp_idx = 0, rst_n = -1;
    bit did_rst = 1'b0;
    logic [15:0] exp_cin;
    vin_at = -1;
    @(negedge clk2);
    cfg_start = 1'b1;
    cfg_bank  = bank;
    if (hold) begin
      s_valid = 1'b1;
      s_data  = 16'h4321;
    end
    #1 chk("s_ready blocked by cfg_start", s_ready, 0);
    for (int n = 1; n <= 90; n++) begin
      @(negedge clk2);
      if (n == 1) cfg_start = 1'b0;
      if (did_rst && n == rst_n + 1) rst = 1'b0;
      if (cload) begin
        cl_cnt++;
        exp_cin = 16'h1000 + {8'h00, bank, exp_idx[5:0]};
        if (n != 3 + exp_idx || caddr != exp_idx[5:0] || cin != exp_cin) cl_bad++;
        exp_idx++;
      end
      if (cfg_done) begin
        done_cnt++;
        done_at = n;
      end
      if (!did_rst && cfg_busy != (n <= 67)) busy_bad++;
      if (valid_in && vin_at < 0) begin
        vin_at = n;
        chk("held sample din", {16'h0, din}, 16'h4321);
        s_valid = 1'b0;
      end
      if (rst_tap >= 0 && !did_rst && cload && caddr == rst_tap[5:0]) begin
        rst     = 1'b1;
        did_rst = 1'b1;
        rst_n   = n;
      end
    end
    chk("load write order/data/timing", cl_bad, 0);
    if (rst_tap >= 0) begin
      chk("aborted load cload count", cl_cnt, rst_tap + 1);
      chk("aborted load cfg_done", done_cnt, 0);
      chk("aborted load coef_valid", coef_valid, 0);
    end else begin
      chk("load cload count", cl_cnt, 64);
      chk("load cfg_done count", done_cnt, 1);
      chk("load cfg_done cycle", done_at, 67);
      chk("load cfg_busy window", busy_bad, 0);
      chk("load coef_valid", coef_valid, 1);
    end
  endtask

  // One sample transaction; FIR answers lat cycles after the accept cycle.
  task automatic send_sample(input logic [15:0] data, input int lat, input logic [15:0] resp,
                             input bit noise, input bit expect_to, input int exp_at,
                             input logic [15:0] exp_data, input string tag);
    int mv_cnt = 0, mv_at = -1, vin_cnt = 0, to_at = -1, limit;
    logic [15:0] md = 16'd0;
    logic err0;
    limit = expect_to ? 4100 : lat + 3;
    err0  = timeout_err;
    @(negedge clk2);
    s_valid = 1'b1;
    s_data  = data;
    #1 chk({tag, " s_ready"}, s_ready, 1);
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk2);
      if (n == 1) begin
        s_valid = 1'b0;
        s_data  = 16'($urandom);
        chk({tag, " valid_in"}, valid_in, 1);
        chk({tag, " din"}, {16'h0, din}, data);
      end
      if (valid_in) vin_cnt++;
      if (m_valid) begin
        mv_cnt++;
        mv_at = n;
        md    = m_data;
      end
      if (!err0 && timeout_err && to_at < 0) to_at = n;
      valid_out = (!expect_to && n == lat) || (noise && n == 1);
      dout      = (n == lat) ? resp : 16'($urandom);
    end
    valid_out = 1'b0;
    chk({tag, " valid_in count"}, vin_cnt, 1);
    if (expect_to) begin
      chk({tag, " m_valid count"}, mv_cnt, 0);
      chk({tag, " timeout cycle"}, to_at, 4098);
      chk({tag, " s_ready after timeout"}, s_ready, 1);
    end else begin
      chk({tag, " m_valid count"}, mv_cnt, 1);
      chk({tag, " m_valid cycle"}, mv_at, exp_at);
      chk({tag, " m_data"}, md, exp_data);
      chk({tag, " timeout_err"}, timeout_err, err0);
    end
  endtask

  typedef struct {
    logic [15:0] s;
    int          lat;
    logic [15:0] d;
    bit          noise;
    int          exp_at;
    logic [15:0] exp_d;
  } vec_t;

  initial begin
    vec_t tbl[4];
    int   v, cnt_a, cnt_b;
    tbl[0] = '{16'h0001, 2,    16'hABCD, 1'b0, 3,    16'hABCD};
    tbl[1] = '{16'hFFFF, 3,    16'h8000, 1'b1, 4,    16'h8000};
    tbl[2] = '{16'h7FFF, 17,   16'h0000, 1'b0, 18,   16'h0000};
    tbl[3] = '{16'h8000, 4097, 16'h7FFF, 1'b0, 4098, 16'h7FFF};

    rst = 1'b1; cfg_start = 1'b0; cfg_bank = 2'd0; s_valid = 1'b0; s_data = 16'sd0;
    valid_out = 1'b0; dout = 16'sd0;
    repeat (3) @(negedge clk2);
    chk("reset cfg_busy", cfg_busy, 0);
    chk("reset cfg_done", cfg_done, 0);
    chk("reset coef_valid", coef_valid, 0);
    chk("reset mem_rd", mem_rd, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset cload/cin/caddr", {cload, cin, caddr}, 0);
    chk("reset s_ready", s_ready, 0);
    chk("reset valid_in/din", {valid_in, din}, 0);
    chk("reset m_valid/m_data", {m_valid, m_data}, 0);
    chk("reset timeout_err", timeout_err, 0);
    rst = 1'b0;
    mon_on = 1'b1;

    // Sample offered before any load must be refused.
    s_valid = 1'b1; s_data = 16'h7FFF;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk2);
      if (s_ready) cnt_a++;
      if (valid_in) cnt_b++;
    end
    s_valid = 1'b0;
    chk("no-coef s_ready", cnt_a, 0);
    chk("no-coef valid_in", cnt_b, 0);

    run_load(2'd1, 1'b0, 30, v);
    run_load(2'd2, 1'b0, -1, v);

    send_sample(16'h8001, 70, 16'h1234, 1'b0, 1'b0, 71, 16'h1234, "first sample");

    // Load and sample requested together: load first, sample right after.
    run_load(2'd0, 1'b1, -1, v);
    chk("held sample accept cycle", v, 69);
    @(negedge clk2); valid_out = 1'b1; dout = 16'sh0BEE;
    @(negedge clk2); valid_out = 1'b0;
    chk("held sample m_valid", m_valid, 1);
    chk("held sample m_data", m_data, 16'h0BEE);

    foreach (tbl[i])
      send_sample(tbl[i].s, tbl[i].lat, tbl[i].d, tbl[i].noise, 1'b0, tbl[i].exp_at, tbl[i].exp_d, "vector");

    // valid_out while idle must not produce a result.
    cnt_a = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk2);
      if (m_valid) cnt_a++;
      valid_out = (i < 5);
      dout = 16'($urandom);
    end
    valid_out = 1'b0;
    chk("idle valid_out ignored", cnt_a, 0);

    for (int i = 0; i < 25; i++) begin
      logic [15:0] sd, rd;
      int lat;
      sd  = 16'($urandom);
      rd  = 16'($urandom);
      lat = $urandom_range(2, 150);
      send_sample(sd, lat, rd, 1'($urandom_range(0, 1)), 1'b0, lat + 1, rd, "random");
    end

    // Reset during WAIT drops the pending result.
    @(negedge clk2);
    s_valid = 1'b1; s_data = 16'sh1111;
    #1 chk("pre-rst s_ready", s_ready, 1);
    @(negedge clk2); s_valid = 1'b0;
    repeat (10) @(negedge clk2);
    rst = 1'b1;
    @(negedge clk2); rst = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk2);
      if (m_valid) cnt_a++;
      valid_out = (i == 3);
      dout = 16'sh5555;
    end
    valid_out = 1'b0;
    chk("rst in WAIT m_valid", cnt_a, 0);
    chk("rst in WAIT coef_valid", coef_valid, 0);

    run_load(2'd3, 1'b0, -1, v);
    send_sample(16'h2222, 0, 16'h0, 1'b0, 1'b1, 0, 16'h0, "timeout");
    send_sample(16'h3333, 5, 16'h0777, 1'b0, 1'b0, 6, 16'h0777, "after timeout");
    chk("timeout_err sticky", timeout_err, 1);
    @(negedge clk2); rst = 1'b1;
    @(negedge clk2); rst = 1'b0;
    chk("timeout_err cleared by rst", timeout_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
